// File: rtl/iob_ila_dump_pkg.sv
// Shared constants for the ILA dump controller: FSM encoding and write strobes.
package iob_ila_dump_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_NS  = 3'd1;
  localparam logic [2:0] ST_WT_NS  = 3'd2;
  localparam logic [2:0] ST_WR_IDX = 3'd3;
  localparam logic [2:0] ST_WR_SEL = 3'd4;
  localparam logic [2:0] ST_RD_DAT = 3'd5;
  localparam logic [2:0] ST_WT_DAT = 3'd6;
  localparam logic [2:0] ST_PUSH   = 3'd7;

  // INDEX is a 16-bit register, SIGNAL_SELECT an 8-bit one.
  localparam logic [3:0] WSTRB_INDEX = 4'b0011;
  localparam logic [3:0] WSTRB_SEL   = 4'b0001;

endpackage

// File: rtl/iob_ila_dump_master.sv
// Single-outstanding IOb-Native request issuer shared by every request state.
// A one-cycle req launches a transaction; address, data and strobe are frozen
// in registers until the slave accepts, then valid drops on the next cycle.
module iob_ila_dump_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                cke,
  input  logic                arst_n,
  input  logic                req,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                m_avalid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  output logic                accepted
);

  assign accepted = m_avalid & m_ready;

  // Hold the request registered until the handshake, accept a new one only when idle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_avalid <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
    end else if (cke) begin
      if (m_avalid) begin
        if (m_ready) m_avalid <= 1'b0;
      end else if (req) begin
        m_avalid <= 1'b1;
        m_addr   <= req_addr;
        m_wdata  <= req_wdata;
        m_wstrb  <= req_wstrb;
      end
    end
  end

endmodule

// File: rtl/iob_ila_dump_ctrl.sv
// Autonomous ILA sample-buffer readout: reads N_SAMPLES, then for every sample
// and slice writes INDEX / SIGNAL_SELECT, reads SAMPLE_DATA and streams it out.
module iob_ila_dump_ctrl
  import iob_ila_dump_pkg::*;
#(
  parameter int ADDR_W             = 5,
  parameter int DATA_W             = 32,
  parameter int BUFFER_W           = 10,
  parameter int N_WORDS            = 1,
  parameter int ADDR_N_SAMPLES     = 'h14,
  parameter int ADDR_INDEX         = 'h10,
  parameter int ADDR_SIGNAL_SELECT = 'h12,
  parameter int ADDR_SAMPLE_DATA   = 'h18
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic                m_avalid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_ready_i,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                s_valid_o,
  output logic [DATA_W-1:0]   s_data_o,
  output logic                s_last_o,
  input  logic                s_ready_i,
  output logic [BUFFER_W-1:0] s_index_o
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [7:0] W_LAST = 8'(N_WORDS - 1);

  logic [2:0]          state;
  logic [BUFFER_W-1:0] idx;
  logic [BUFFER_W-1:0] n;
  logic [7:0]          w;
  logic                req_sent;
  logic                n_loaded;
  logic                abort_pend;
  logic                abort_any;
  logic                last_word;
  logic                last_sample;
  logic                is_req_state;
  logic                req;
  logic                accepted;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [STRB_W-1:0]   req_wstrb;

  assign abort_any   = abort_pend | abort_i;
  assign last_word   = (w == W_LAST);
  assign last_sample = (idx == (n - BUFFER_W'(1)));

  // Request contents per state; a request launches once per state visit unless an abort is pending.
  always_comb begin
    req_addr     = '0;
    req_wdata    = '0;
    req_wstrb    = '0;
    is_req_state = 1'b1;
    case (state)
      ST_RD_NS:  req_addr = ADDR_W'(ADDR_N_SAMPLES);
      ST_WR_IDX: begin
        req_addr  = ADDR_W'(ADDR_INDEX);
        req_wdata = DATA_W'(idx);
        req_wstrb = STRB_W'(WSTRB_INDEX);
      end
      ST_WR_SEL: begin
        req_addr  = ADDR_W'(ADDR_SIGNAL_SELECT);
        req_wdata = DATA_W'(w);
        req_wstrb = STRB_W'(WSTRB_SEL);
      end
      ST_RD_DAT: req_addr = ADDR_W'(ADDR_SAMPLE_DATA);
      default:   is_req_state = 1'b0;
    endcase
    req = is_req_state & ~req_sent & ~abort_any;
  end

  iob_ila_dump_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_master (
    .clk       (clk_i),
    .cke       (cke_i),
    .arst_n    (arst_n_i),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .m_avalid  (m_avalid_o),
    .m_addr    (m_addr_o),
    .m_wdata   (m_wdata_o),
    .m_wstrb   (m_wstrb_o),
    .m_ready   (m_ready_i),
    .accepted  (accepted)
  );

  // Sequencer: walks samples and slices, aborting only between transactions.
  // The sample count is registered before it is tested, so an empty buffer
  // returns to IDLE two cycles after its read data arrives.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      n          <= '0;
      w          <= '0;
      req_sent   <= 1'b0;
      n_loaded   <= 1'b0;
      abort_pend <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      aborted_o  <= 1'b0;
      s_valid_o  <= 1'b0;
      s_data_o   <= '0;
      s_last_o   <= 1'b0;
      s_index_o  <= '0;
    end else if (cke_i) begin
      done_o <= 1'b0;
      if (state != ST_IDLE && abort_i) abort_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state      <= ST_RD_NS;
            busy_o     <= 1'b1;
            idx        <= '0;
            w          <= '0;
            aborted_o  <= 1'b0;
            abort_pend <= 1'b0;
            req_sent   <= 1'b0;
            n_loaded   <= 1'b0;
          end
        end
        ST_RD_NS, ST_WR_IDX, ST_WR_SEL, ST_RD_DAT: begin
          if (!req_sent) begin
            if (abort_any) begin
              state      <= ST_IDLE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              aborted_o  <= 1'b1;
              abort_pend <= 1'b0;
            end else begin
              req_sent <= 1'b1;
            end
          end else if (accepted) begin
            req_sent <= 1'b0;
            case (state)
              ST_RD_NS:  state <= ST_WT_NS;
              ST_WR_IDX: state <= ST_WR_SEL;
              ST_WR_SEL: state <= ST_RD_DAT;
              default:   state <= ST_WT_DAT;
            endcase
          end
        end
        ST_WT_NS: begin
          if (!n_loaded) begin
            if (m_rvalid_i) begin
              n        <= m_rdata_i[BUFFER_W-1:0];
              n_loaded <= 1'b1;
            end
          end else begin
            n_loaded <= 1'b0;
            if (abort_any) begin
              state      <= ST_IDLE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              aborted_o  <= 1'b1;
              abort_pend <= 1'b0;
            end else if (n == '0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state <= ST_WR_IDX;
            end
          end
        end
        ST_WT_DAT: begin
          if (m_rvalid_i) begin
            if (abort_any) begin
              state      <= ST_IDLE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              aborted_o  <= 1'b1;
              abort_pend <= 1'b0;
            end else begin
              state     <= ST_PUSH;
              s_valid_o <= 1'b1;
              s_data_o  <= m_rdata_i;
              s_index_o <= idx;
              s_last_o  <= last_sample & last_word;
            end
          end
        end
        ST_PUSH: begin
          if (s_ready_i) begin
            s_valid_o <= 1'b0;
            s_last_o  <= 1'b0;
            if (abort_any) begin
              state      <= ST_IDLE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              aborted_o  <= 1'b1;
              abort_pend <= 1'b0;
            end else if (!last_word) begin
              w     <= w + 8'd1;
              state <= ST_WR_SEL;
            end else if (!last_sample) begin
              w     <= '0;
              idx   <= idx + BUFFER_W'(1);
              state <= ST_WR_IDX;
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_ila_dump_ctrl.sv
// Bench for iob_ila_dump_ctrl: behavioural ILA register slave, stream sink
// recorder and directed scenarios with hand-computed expectations.
module tb_iob_ila_dump_ctrl;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int BUFFER_W = 10;
  localparam int N_WORDS  = 2;

  logic                clk = 1'b0;
  logic                cke = 1'b1;
  logic                arst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                busy_o, done_o, aborted_o;
  logic                m_avalid_o;
  logic [ADDR_W-1:0]   m_addr_o;
  logic [DATA_W-1:0]   m_wdata_o;
  logic [DATA_W/8-1:0] m_wstrb_o;
  logic                m_ready = 1'b0;
  logic                m_rvalid = 1'b0;
  logic [DATA_W-1:0]   m_rdata = '0;
  logic                s_valid_o, s_last_o;
  logic [DATA_W-1:0]   s_data_o;
  logic [BUFFER_W-1:0] s_index_o;
  logic                s_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model configuration and bookkeeping
  int          ns_cfg = 0;
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  bit          rd_pend = 0;
  int          rd_wait = 0;
  logic [31:0] rd_val = '0;
  bit          rd_is_ns = 0;
  logic [15:0] index_reg = '0;
  logic [7:0]  sel_reg = '0;
  int          bad_acc = 0;
  int          n_reads = 0;
  int          dat_reads = 0;
  int          rv_ns_cyc = 0;
  int          rv_last_cyc = 0;

  // sink recorder
  int          hold_word = -1;
  int          sink_hold = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] words[$];
  logic [9:0]  idxs[$];
  logic        lasts[$];

  iob_ila_dump_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .N_WORDS(N_WORDS),
    .ADDR_N_SAMPLES('h14), .ADDR_INDEX('h10), .ADDR_SIGNAL_SELECT('h12), .ADDR_SAMPLE_DATA('h18)
  ) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .m_avalid_o(m_avalid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_ready_i(m_ready), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
    .s_valid_o(s_valid_o), .s_data_o(s_data_o), .s_last_o(s_last_o), .s_ready_i(s_ready),
    .s_index_o(s_index_o)
  );

  always #5 clk = ~clk;

  // cycle stamp, read on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample_word(input logic [15:0] i, input logic [7:0] s);
    return {16'hD000, i[7:0], s};
  endfunction

  // ILA register slave: optional ready stall, read data one cycle after acceptance
  always @(negedge clk) begin
    if (!arst_n) begin
      m_ready = 1'b0; m_rvalid = 1'b0; stall_cnt = 0; rd_pend = 0;
    end else if (cke) begin
      m_ready = 1'b0; m_rvalid = 1'b0;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          m_rvalid = 1'b1; m_rdata = rd_val; rd_pend = 0; rv_last_cyc = cyc;
          if (rd_is_ns) rv_ns_cyc = cyc;
        end else rd_wait--;
      end
      if (m_avalid_o) begin
        if (stall_cnt < stall_cfg) stall_cnt++;
        else begin
          stall_cnt = 0; m_ready = 1'b1;
          if (m_wstrb_o == 4'b0000) begin
            rd_pend = 1; rd_wait = 0; rd_is_ns = (m_addr_o == 5'h14);
            if (m_addr_o == 5'h14) begin rd_val = 32'(ns_cfg); n_reads++; end
            else if (m_addr_o == 5'h18) begin rd_val = sample_word(index_reg, sel_reg); dat_reads++; end
            else begin rd_val = 32'hBAD0_0000; bad_acc++; end
          end else if (m_addr_o == 5'h10 && m_wstrb_o == 4'b0011) index_reg = m_wdata_o[15:0];
          else if (m_addr_o == 5'h12 && m_wstrb_o == 4'b0001) sel_reg = m_wdata_o[7:0];
          else bad_acc++;
        end
      end
    end
  end

  // stream sink and done-pulse recorder
  always @(negedge clk) begin
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (s_valid_o && sink_hold > 0 && words.size() == hold_word) begin
      s_ready = 1'b0; sink_hold--;
    end else s_ready = 1'b1;
    if (s_valid_o && s_ready) begin
      words.push_back(s_data_o); idxs.push_back(s_index_o); lasts.push_back(s_last_o);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    words.delete(); idxs.delete(); lasts.delete();
    done_cnt = 0; bad_acc = 0; n_reads = 0; dat_reads = 0;
    hold_word = -1; sink_hold = 0; stall_cfg = 0;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt != 0) ok = 1;
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; cke = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    arst_n = 1'b1;
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_aborted: got %b expected 0", aborted_o); end
    checks++; if (m_avalid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_avalid: got %b expected 0", m_avalid_o); end
    checks++; if (m_addr_o !== 5'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", m_addr_o); end
    checks++; if (m_wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", m_wdata_o); end
    checks++; if (m_wstrb_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_wstrb: got %h expected 0", m_wstrb_o); end
    checks++; if (s_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_svalid: got %b expected 0", s_valid_o); end
    checks++; if (s_last_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_slast: got %b expected 0", s_last_o); end
    checks++; if (s_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_sdata: got %h expected 0", s_data_o); end
    checks++; if (s_index_o !== 10'h0) begin errors++; $display("[TB] FAIL reset_sindex: got %h expected 0", s_index_o); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_data [6] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0100,
                                  32'hD000_0101, 32'hD000_0200, 32'hD000_0201};
    logic [9:0]  exp_idx [6]  = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd2, 10'd2};
    bit ok;
    clear_logs(); ns_cfg = 3;
    pulse_start();
    wait_done(600, ok);
    repeat (4) tick();
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: got no done, expected done"); end
    checks++; if (words.size() != 6) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 6", words.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < words.size()) begin
        checks++; if (words[k] !== exp_data[k]) begin errors++; $display("[TB] FAIL basic_data%0d: got %h expected %h", k, words[k], exp_data[k]); end
        checks++; if (idxs[k] !== exp_idx[k]) begin errors++; $display("[TB] FAIL basic_index%0d: got %0d expected %0d", k, idxs[k], exp_idx[k]); end
        checks++; if (lasts[k] !== (k == 5)) begin errors++; $display("[TB] FAIL basic_last%0d: got %b expected %b", k, lasts[k], (k == 5)); end
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", busy_o); end
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_aborted: got %b expected 0", aborted_o); end
    checks++; if (bad_acc != 0) begin errors++; $display("[TB] FAIL basic_bus_access: got %0d bad accesses expected 0", bad_acc); end
  endtask

  task automatic test_zero_samples();
    bit ok;
    clear_logs(); ns_cfg = 0;
    pulse_start();
    wait_done(100, ok);
    repeat (4) tick();
    checks++; if (!ok) begin errors++; $display("[TB] FAIL zero_timeout: got no done, expected done"); end
    checks++; if (words.size() != 0) begin errors++; $display("[TB] FAIL zero_words: got %0d expected 0", words.size()); end
    checks++; if (done_cyc - rv_ns_cyc != 2) begin errors++; $display("[TB] FAIL zero_done_latency: got %0d expected 2", done_cyc - rv_ns_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d expected 1", done_cnt); end
    checks++; if (dat_reads != 0) begin errors++; $display("[TB] FAIL zero_data_reads: got %0d expected 0", dat_reads); end
  endtask

  task automatic test_slave_stall();
    bit ok = 0;
    bit prev_valid = 0, prev_ready = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_wdata = '0;
    logic [3:0] prev_wstrb = '0;
    int unstable = 0, run = 0, max_run = 0;
    clear_logs(); ns_cfg = 1; stall_cfg = 5;
    pulse_start();
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (m_avalid_o && prev_valid && !prev_ready &&
          (m_addr_o !== prev_addr || m_wdata_o !== prev_wdata || m_wstrb_o !== prev_wstrb)) unstable++;
      run = m_avalid_o ? run + 1 : 0;
      if (run > max_run) max_run = run;
      prev_valid = m_avalid_o; prev_ready = m_ready;
      prev_addr = m_addr_o; prev_wdata = m_wdata_o; prev_wstrb = m_wstrb_o;
      if (done_cnt != 0) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_timeout: got no done, expected done"); end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL stall_req_stable: got %0d changes expected 0", unstable); end
    checks++; if (max_run != 6) begin errors++; $display("[TB] FAIL stall_avalid_run: got %0d expected 6", max_run); end
    checks++; if (words.size() != 2) begin errors++; $display("[TB] FAIL stall_count: got %0d expected 2", words.size()); end
    if (words.size() == 2) begin
      checks++; if (words[0] !== 32'hD000_0000) begin errors++; $display("[TB] FAIL stall_data0: got %h expected d0000000", words[0]); end
      checks++; if (words[1] !== 32'hD000_0001) begin errors++; $display("[TB] FAIL stall_data1: got %h expected d0000001", words[1]); end
    end
  endtask

  task automatic test_sink_stall();
    bit ok = 0;
    int stall_ticks = 0, data_changed = 0, bus_during = 0;
    logic [31:0] held = '0;
    clear_logs(); ns_cfg = 2; hold_word = 1; sink_hold = 10;
    pulse_start();
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      if (s_valid_o && !s_ready) begin
        if (stall_ticks == 0) held = s_data_o;
        else if (s_data_o !== held) data_changed++;
        if (m_avalid_o) bus_during++;
        stall_ticks++;
      end
      if (done_cnt != 0) ok = 1;
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL sink_timeout: got no done, expected done"); end
    checks++; if (stall_ticks != 10) begin errors++; $display("[TB] FAIL sink_stall_len: got %0d expected 10", stall_ticks); end
    checks++; if (held !== 32'hD000_0001) begin errors++; $display("[TB] FAIL sink_held_word: got %h expected d0000001", held); end
    checks++; if (data_changed != 0) begin errors++; $display("[TB] FAIL sink_data_hold: got %0d changes expected 0", data_changed); end
    checks++; if (bus_during != 0) begin errors++; $display("[TB] FAIL sink_no_bus: got %0d request cycles expected 0", bus_during); end
    checks++; if (words.size() != 4) begin errors++; $display("[TB] FAIL sink_count: got %0d expected 4", words.size()); end
    if (words.size() == 4) begin
      checks++; if (words[2] !== 32'hD000_0100) begin errors++; $display("[TB] FAIL sink_data2: got %h expected d0000100", words[2]); end
    end
  endtask

  task automatic test_abort();
    bit ok, found = 0;
    clear_logs(); ns_cfg = 2; stall_cfg = 3;
    pulse_start();
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_avalid_o && m_addr_o == 5'h18) found = 1;
    end
    abort = 1'b1; tick(); abort = 1'b0;
    wait_done(200, ok);
    repeat (4) tick();
    checks++; if (!found) begin errors++; $display("[TB] FAIL abort_no_read: got no SAMPLE_DATA request, expected one"); end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_timeout: got no done, expected done"); end
    checks++; if (aborted_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_flag: got %b expected 1", aborted_o); end
    checks++; if (words.size() != 0) begin errors++; $display("[TB] FAIL abort_words: got %0d expected 0", words.size()); end
    checks++; if (dat_reads != 1) begin errors++; $display("[TB] FAIL abort_reads: got %0d expected 1", dat_reads); end
    checks++; if (done_cyc - rv_last_cyc != 1) begin errors++; $display("[TB] FAIL abort_rvalid_consumed: got %0d expected 1", done_cyc - rv_last_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL abort_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_o); end
    clear_logs(); ns_cfg = 1;
    pulse_start();
    checks++; if (aborted_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_clear: got %b expected 0", aborted_o); end
    wait_done(300, ok);
    checks++; if (words.size() != 2) begin errors++; $display("[TB] FAIL abort_restart_count: got %0d expected 2", words.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    clear_logs(); ns_cfg = 3;
    pulse_start();
    for (int i = 0; i < 300 && words.size() < 2; i++) tick();
    #2 arst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy_o); end
    checks++; if (m_avalid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_avalid: got %b expected 0", m_avalid_o); end
    checks++; if (s_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_svalid: got %b expected 0", s_valid_o); end
    checks++; if (s_data_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_sdata: got %h expected 0", s_data_o); end
    checks++; if (s_index_o !== 10'h0) begin errors++; $display("[TB] FAIL midrst_sindex: got %h expected 0", s_index_o); end
    checks++; if (m_addr_o !== 5'h0) begin errors++; $display("[TB] FAIL midrst_addr: got %h expected 0", m_addr_o); end
    repeat (2) tick();
    arst_n = 1'b1;
    clear_logs(); ns_cfg = 3;
    pulse_start();
    wait_done(600, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_timeout: got no done, expected done"); end
    checks++; if (words.size() != 6) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 6", words.size()); end
    if (words.size() != 0) begin
      checks++; if (words[0] !== 32'hD000_0000) begin errors++; $display("[TB] FAIL midrst_first_data: got %h expected d0000000", words[0]); end
      checks++; if (idxs[0] !== 10'd0) begin errors++; $display("[TB] FAIL midrst_first_index: got %0d expected 0", idxs[0]); end
    end
  endtask

  task automatic test_cke_freeze();
    bit ok, seen = 0;
    int diffs = 0;
    logic [31:0] snap_data;
    logic [9:0]  snap_idx;
    logic        snap_valid, snap_busy;
    clear_logs(); ns_cfg = 1; hold_word = 0; sink_hold = 8;
    pulse_start();
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (s_valid_o) seen = 1;
    end
    tick();
    cke = 1'b0;
    snap_data = s_data_o; snap_idx = s_index_o; snap_valid = s_valid_o; snap_busy = busy_o;
    repeat (3) begin
      tick();
      if (s_data_o !== snap_data || s_index_o !== snap_idx || s_valid_o !== snap_valid ||
          busy_o !== snap_busy || m_avalid_o !== 1'b0) diffs++;
    end
    cke = 1'b1;
    wait_done(300, ok);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL cke_no_word: got no s_valid, expected one"); end
    checks++; if (snap_valid !== 1'b1) begin errors++; $display("[TB] FAIL cke_snap_valid: got %b expected 1", snap_valid); end
    checks++; if (diffs != 0) begin errors++; $display("[TB] FAIL cke_freeze: got %0d changed cycles expected 0", diffs); end
    checks++; if (words.size() != 2) begin errors++; $display("[TB] FAIL cke_count: got %0d expected 2", words.size()); end
    if (words.size() == 2) begin
      checks++; if (words[1] !== 32'hD000_0001) begin errors++; $display("[TB] FAIL cke_data1: got %h expected d0000001", words[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_samples();
    test_slave_stall();
    test_sink_stall();
    test_abort();
    test_reset_mid();
    test_cke_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
